// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: lets N_REQ CMU requesters share one FP adder and one FP
// multiplier. Each unit has its own round-robin controller. Results go back
// to the requester that owns the operation. A requester may have only one
// operation in flight at a time.
module fp_unit_arbiter #(
  parameter int DBL_WIDTH = 64,
  parameter int N_REQ     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_op,
  input  logic [N_REQ*DBL_WIDTH-1:0] req_a,
  input  logic [N_REQ*DBL_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]           req_gnt,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [N_REQ*DBL_WIDTH-1:0] rsp_data,
  output logic                       add_go,
  output logic                       mul_go,
  input  logic                       add_ready,
  input  logic                       mul_ready,
  input  logic                       add_finish,
  input  logic                       mul_finish,
  output logic [DBL_WIDTH-1:0]       add_a,
  output logic [DBL_WIDTH-1:0]       add_b,
  output logic [DBL_WIDTH-1:0]       mul_a,
  output logic [DBL_WIDTH-1:0]       mul_b,
  input  logic [DBL_WIDTH-1:0]       add_r,
  input  logic [DBL_WIDTH-1:0]       mul_r,
  output logic                       err_spurious
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {U_IDLE, U_BUSY} unit_state_t;

  unit_state_t      add_state, mul_state;
  logic [IDX_W-1:0] add_owner, mul_owner;
  logic [IDX_W-1:0] add_rr, mul_rr;
  logic [N_REQ-1:0] outstanding;

  logic [N_REQ-1:0] add_elig, mul_elig;
  logic [IDX_W-1:0] add_win, mul_win;
  logic             add_issue, mul_issue;
  logic             add_done, mul_done;
  logic [N_REQ-1:0] gnt_next, rsp_next, outstanding_next;

  // First eligible index at or after ptr, wrapping modulo N_REQ. The scan
  // runs from the farthest offset down, so the nearest hit is the one kept.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] win;
    int               idx;
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (elig[idx]) win = IDX_W'(idx);
    end
    return win;
  endfunction

  // Pointer to the slot just after the winner, wrapping to 0.
  function automatic logic [IDX_W-1:0] rr_after(input logic [IDX_W-1:0] win);
    return (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
  endfunction

  // Work out eligibility, the winners, the issue and completion events, and
  // the next grant, response and outstanding vectors.
  always_comb begin
    add_elig  = req_valid & ~req_op & ~outstanding;
    mul_elig  = req_valid &  req_op & ~outstanding;
    add_win   = rr_pick(add_elig, add_rr);
    mul_win   = rr_pick(mul_elig, mul_rr);
    add_issue = (add_state == U_IDLE) && add_ready && (|add_elig);
    mul_issue = (mul_state == U_IDLE) && mul_ready && (|mul_elig);
    add_done  = (add_state == U_BUSY) && add_finish;
    mul_done  = (mul_state == U_BUSY) && mul_finish;
    gnt_next  = '0;
    rsp_next  = '0;
    if (add_issue) gnt_next[add_win]   = 1'b1;
    if (mul_issue) gnt_next[mul_win]   = 1'b1;
    if (add_done)  rsp_next[add_owner] = 1'b1;
    if (mul_done)  rsp_next[mul_owner] = 1'b1;
    outstanding_next = (outstanding & ~rsp_next) | gnt_next;
  end

  // Adder controller. It issues to the round-robin winner, then waits for
  // the unit to finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_state <= U_IDLE;
      add_owner <= '0;
      add_rr    <= '0;
      add_go    <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      add_go <= add_issue;
      case (add_state)
        U_IDLE: begin
          if (add_issue) begin
            add_a     <= req_a[add_win*DBL_WIDTH +: DBL_WIDTH];
            add_b     <= req_b[add_win*DBL_WIDTH +: DBL_WIDTH];
            add_owner <= add_win;
            add_rr    <= rr_after(add_win);
            add_state <= U_BUSY;
          end
        end
        U_BUSY: begin
          if (add_finish) add_state <= U_IDLE;
        end
        default: add_state <= U_IDLE;
      endcase
    end
  end

  // Multiplier controller. It behaves the same way as the adder controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_state <= U_IDLE;
      mul_owner <= '0;
      mul_rr    <= '0;
      mul_go    <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      mul_go <= mul_issue;
      case (mul_state)
        U_IDLE: begin
          if (mul_issue) begin
            mul_a     <= req_a[mul_win*DBL_WIDTH +: DBL_WIDTH];
            mul_b     <= req_b[mul_win*DBL_WIDTH +: DBL_WIDTH];
            mul_owner <= mul_win;
            mul_rr    <= rr_after(mul_win);
            mul_state <= U_BUSY;
          end
        end
        U_BUSY: begin
          if (mul_finish) mul_state <= U_IDLE;
        end
        default: mul_state <= U_IDLE;
      endcase
    end
  end

  // Requester-side state is shared by both units: grant and response pulses,
  // the outstanding mask, result slots and the sticky spurious-finish flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_gnt      <= '0;
      rsp_valid    <= '0;
      outstanding  <= '0;
      rsp_data     <= '0;
      err_spurious <= 1'b0;
    end else begin
      req_gnt     <= gnt_next;
      rsp_valid   <= rsp_next;
      outstanding <= outstanding_next;
      if (add_done) rsp_data[add_owner*DBL_WIDTH +: DBL_WIDTH] <= add_r;
      if (mul_done) rsp_data[mul_owner*DBL_WIDTH +: DBL_WIDTH] <= mul_r;
      if (((add_state == U_IDLE) && add_finish) ||
          ((mul_state == U_IDLE) && mul_finish))
        err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter: directed bench for fp_unit_arbiter. The bench plays
// the part of the requesters and of both FP units. Expected values are
// worked out by hand for each scenario.
module tb_fp_unit_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid, req_op, req_gnt, rsp_valid;
  logic [NR*DW-1:0] req_a, req_b, rsp_data;
  logic             add_go, mul_go, add_ready, mul_ready, add_finish, mul_finish;
  logic [DW-1:0]    add_a, add_b, mul_a, mul_b, add_r, mul_r;
  logic             err_spurious;

  int checks = 0;
  int passes = 0;

  fp_unit_arbiter #(.DBL_WIDTH(DW), .N_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .add_go(add_go), .mul_go(mul_go),
    .add_ready(add_ready), .mul_ready(mul_ready),
    .add_finish(add_finish), .mul_finish(mul_finish),
    .add_a(add_a), .add_b(add_b), .mul_a(mul_a), .mul_b(mul_b),
    .add_r(add_r), .mul_r(mul_r),
    .err_spurious(err_spurious)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Advance one cycle. Sampling and driving happen 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    add_ready = 1'b1; mul_ready = 1'b1; add_finish = 1'b0; mul_finish = 1'b0;
    add_r = '0; mul_r = '0;
    step(); step();
    checks++; if (req_gnt !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b want 0000", req_gnt); else passes++;
    checks++; if (rsp_valid !== 4'b0000) $display("[TB] FAIL reset_rsp_valid: got %b want 0000", rsp_valid); else passes++;
    checks++; if ({add_go, mul_go, err_spurious} !== 3'b000) $display("[TB] FAIL reset_flags: got %b want 000", {add_go, mul_go, err_spurious}); else passes++;
    checks++; if (rsp_data !== '0 || add_a !== '0 || mul_b !== '0) $display("[TB] FAIL reset_data: got %h want 0", rsp_data); else passes++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    req_valid = 4'b0001; req_op = 4'b0000;
    req_a[0 +: DW] = 64'h3FF0000000000000; req_b[0 +: DW] = 64'h4000000000000000;
    step();
    checks++; if (req_gnt !== 4'b0001) $display("[TB] FAIL add_gnt: got %b want 0001", req_gnt); else passes++;
    checks++; if ({add_go, mul_go} !== 2'b10) $display("[TB] FAIL add_go: got %b want 10", {add_go, mul_go}); else passes++;
    checks++; if (add_a !== 64'h3FF0000000000000 || add_b !== 64'h4000000000000000) $display("[TB] FAIL add_operands: got %h %h want 3ff0000000000000 4000000000000000", add_a, add_b); else passes++;
    req_valid = 4'b0000;
    step();
    checks++; if ({add_go, req_gnt} !== 5'b0) $display("[TB] FAIL add_go_pulse: got %b want 00000", {add_go, req_gnt}); else passes++;
    step(); step(); step(); step();
    add_finish = 1'b1; add_r = 64'h4008000000000000;
    step();
    add_finish = 1'b0;
    checks++; if (rsp_valid !== 4'b0001) $display("[TB] FAIL add_rsp_valid: got %b want 0001", rsp_valid); else passes++;
    checks++; if (rsp_data[0 +: DW] !== 64'h4008000000000000) $display("[TB] FAIL add_rsp_data: got %h want 4008000000000000", rsp_data[0 +: DW]); else passes++;
    step();
    checks++; if (rsp_valid !== 4'b0000) $display("[TB] FAIL add_rsp_pulse: got %b want 0000", rsp_valid); else passes++;
    checks++; if (rsp_data[0 +: DW] !== 64'h4008000000000000) $display("[TB] FAIL add_rsp_hold: got %h want 4008000000000000", rsp_data[0 +: DW]); else passes++;
  endtask

  task automatic test_contention();
    logic [DW-1:0] res [4];
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = 64'hA000 + 64'(i);
      req_b[i*DW +: DW] = 64'hB000 + 64'(i);
      res[i]            = 64'hC0DE_0000_0000_0000 + 64'(i * 17);
    end
    req_op = 4'b1111; req_valid = 4'b1111;
    step();
    for (int i = 0; i < NR; i++) begin
      checks++; if (req_gnt !== 4'(1 << i) || mul_go !== 1'b1) $display("[TB] FAIL cont_gnt%0d: got %b go %b want %b go 1", i, req_gnt, mul_go, 4'(1 << i)); else passes++;
      checks++; if (mul_a !== 64'hA000 + 64'(i)) $display("[TB] FAIL cont_mul_a%0d: got %h want %h", i, mul_a, 64'hA000 + 64'(i)); else passes++;
      req_valid[i] = 1'b0;
      step(); step();
      mul_finish = 1'b1; mul_r = res[i];
      step();
      mul_finish = 1'b0;
      checks++; if (rsp_valid !== 4'(1 << i)) $display("[TB] FAIL cont_rsp%0d: got %b want %b", i, rsp_valid, 4'(1 << i)); else passes++;
      checks++; if (rsp_data[i*DW +: DW] !== res[i]) $display("[TB] FAIL cont_data%0d: got %h want %h", i, rsp_data[i*DW +: DW], res[i]); else passes++;
      if (i < NR - 1) step();
    end
    checks++; if (rsp_data[0 +: DW] !== res[0]) $display("[TB] FAIL cont_hold0: got %h want %h", rsp_data[0 +: DW], res[0]); else passes++;
    // The pointer wrapped to 0, so requester 0 beats requester 3.
    req_valid = 4'b1001;
    step();
    checks++; if (req_gnt !== 4'b0001) $display("[TB] FAIL cont_wrap: got %b want 0001", req_gnt); else passes++;
    req_valid = 4'b1000;
    step(); mul_finish = 1'b1; step(); mul_finish = 1'b0;
    step();
    checks++; if (req_gnt !== 4'b1000) $display("[TB] FAIL cont_next3: got %b want 1000", req_gnt); else passes++;
    req_valid = 4'b0000;
    step(); mul_finish = 1'b1; step(); mul_finish = 1'b0;
    step();
  endtask

  task automatic test_concurrency();
    req_op = 4'b0100; req_valid = 4'b0110;
    req_a[1*DW +: DW] = 64'h1111; req_a[2*DW +: DW] = 64'h2222;
    step();
    checks++; if (req_gnt !== 4'b0110 || {add_go, mul_go} !== 2'b11) $display("[TB] FAIL conc_gnt: got %b go %b want 0110 go 11", req_gnt, {add_go, mul_go}); else passes++;
    checks++; if (add_a !== 64'h1111 || mul_a !== 64'h2222) $display("[TB] FAIL conc_operands: got %h %h want 1111 2222", add_a, mul_a); else passes++;
    req_valid = 4'b0000;
    step(); step();
    add_finish = 1'b1; mul_finish = 1'b1; add_r = 64'hADD1; mul_r = 64'h3E12;
    step();
    add_finish = 1'b0; mul_finish = 1'b0;
    checks++; if (rsp_valid !== 4'b0110) $display("[TB] FAIL conc_rsp: got %b want 0110", rsp_valid); else passes++;
    checks++; if (rsp_data[1*DW +: DW] !== 64'hADD1 || rsp_data[2*DW +: DW] !== 64'h3E12) $display("[TB] FAIL conc_data: got %h %h want add1 3e12", rsp_data[1*DW +: DW], rsp_data[2*DW +: DW]); else passes++;
    step();
  endtask

  task automatic test_back_to_back();
    req_op = 4'b0000; req_valid = 4'b0001;
    step();
    checks++; if (req_gnt !== 4'b0001) $display("[TB] FAIL b2b_first_gnt: got %b want 0001", req_gnt); else passes++;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (req_gnt !== 4'b0000 || add_go !== 1'b0) $display("[TB] FAIL b2b_masked%0d: got %b go %b want 0000 go 0", k, req_gnt, add_go); else passes++;
    end
    add_finish = 1'b1; add_r = 64'h5555;
    step();
    add_finish = 1'b0;
    checks++; if (rsp_valid !== 4'b0001 || req_gnt !== 4'b0000) $display("[TB] FAIL b2b_rsp: got rsp %b gnt %b want rsp 0001 gnt 0000", rsp_valid, req_gnt); else passes++;
    step();
    checks++; if (req_gnt !== 4'b0001 || add_go !== 1'b1) $display("[TB] FAIL b2b_regrant: got %b go %b want 0001 go 1", req_gnt, add_go); else passes++;
    req_valid = 4'b0000;
    step(); add_finish = 1'b1; step(); add_finish = 1'b0;
    step();
  endtask

  task automatic test_ready_stall();
    add_ready = 1'b0; req_op = 4'b0000; req_valid = 4'b1000;
    req_a[3*DW +: DW] = 64'h3333;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (req_gnt !== 4'b0000 || add_go !== 1'b0) $display("[TB] FAIL stall_cycle%0d: got %b go %b want 0000 go 0", k, req_gnt, add_go); else passes++;
    end
    add_ready = 1'b1;
    step();
    checks++; if (req_gnt !== 4'b1000 || add_go !== 1'b1 || add_a !== 64'h3333) $display("[TB] FAIL stall_release: got %b go %b a %h want 1000 go 1 a 3333", req_gnt, add_go, add_a); else passes++;
    req_valid = 4'b0000;
    step(); add_finish = 1'b1; step(); add_finish = 1'b0;
    step();
  endtask

  task automatic test_spurious_reset();
    add_finish = 1'b1;
    step();
    add_finish = 1'b0;
    checks++; if (err_spurious !== 1'b1 || rsp_valid !== 4'b0000) $display("[TB] FAIL spur_set: got err %b rsp %b want err 1 rsp 0000", err_spurious, rsp_valid); else passes++;
    step(); step(); step();
    checks++; if (err_spurious !== 1'b1) $display("[TB] FAIL spur_sticky: got %b want 1", err_spurious); else passes++;
    req_op = 4'b0010; req_valid = 4'b0010; req_a[1*DW +: DW] = 64'h7777;
    step();
    checks++; if (req_gnt !== 4'b0010 || mul_go !== 1'b1) $display("[TB] FAIL rst_pre_gnt: got %b go %b want 0010 go 1", req_gnt, mul_go); else passes++;
    req_valid = 4'b0000;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if ({req_gnt, rsp_valid, add_go, mul_go, err_spurious} !== 11'b0) $display("[TB] FAIL rst_async_flags: got %b want 0", {req_gnt, rsp_valid, add_go, mul_go, err_spurious}); else passes++;
    checks++; if (rsp_data !== '0 || mul_a !== '0) $display("[TB] FAIL rst_async_data: got %h %h want 0", rsp_data, mul_a); else passes++;
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (rsp_valid !== 4'b0000 || err_spurious !== 1'b0) $display("[TB] FAIL rst_after%0d: got rsp %b err %b want 0000 0", k, rsp_valid, err_spurious); else passes++;
    end
  endtask

  // Run the scenarios in order, then print the summary line.
  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_concurrency();
    test_back_to_back();
    test_ready_stall();
    test_spurious_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fp_unit_arbiter.md
# fp_unit_arbiter

Shares one fp_adder and one fp_multiplier between N_REQ independent CMU requesters. Each requester posts a single add or multiply; the arbiter grants each unit round-robin, drives the unit's valid/operand pins, and routes the result back to the owning requester. It sits between the per-element CMU state machines and the shared FP units, replacing per-CMU private adder and multiplier instances.

## Interface
- DBL_WIDTH, 64, operand/result width (IEEE-754 double)
- N_REQ, 4, number of requesters (2..8)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  request pending, held until granted
- req_op  in  N_REQ  per-requester op: 0 = add, 1 = mul
- req_a, req_b  in  N_REQ*DBL_WIDTH  operands, requester i at bits [i*DBL_WIDTH +: DBL_WIDTH]
- req_gnt  out  N_REQ  one-cycle pulse: operands captured
- rsp_valid  out  N_REQ  one-cycle pulse: result available
- rsp_data  out  N_REQ*DBL_WIDTH  per-requester result, held until that requester's next rsp_valid
- add_go, mul_go  out  1  unit start pulse (drives unit valid)
- add_ready, mul_ready  in  1  unit can accept
- add_finish, mul_finish  in  1  unit result pulse
- add_a, add_b, mul_a, mul_b  out  DBL_WIDTH  unit operands, registered
- add_r, mul_r  in  DBL_WIDTH  unit results
- err_spurious  out  1  sticky: finish seen while that unit is idle

## Operation
- Two identical, independent unit controllers, ADD and MUL. Each has state U_IDLE / U_BUSY, an owner index, and a round-robin pointer.
- Requester i is eligible for a unit when: req_valid[i]=1, req_op[i] matches the unit, and outstanding[i]=0.
- outstanding[i] sets on grant and clears on response. A requester has at most one op in flight.
- U_IDLE with unit ready=1 and at least one eligible requester:
  - Winner is the first eligible index at or after rr_ptr, wrapping modulo N_REQ.
  - Register: operands into unit a/b, go=1, req_gnt[winner]=1, owner=winner, outstanding[winner]=1, rr_ptr=winner+1 (mod N_REQ), state goes to U_BUSY.
- U_IDLE with ready=0: no grant; wait.
- U_BUSY with finish=1:
  - Register: rsp_data[owner] = unit result, rsp_valid[owner]=1, clear outstanding[owner], state goes to U_IDLE.
- U_BUSY with finish=0: hold. go is low in every cycle except the issue cycle. There is no timeout.
- Finish while U_IDLE: ignored for data; set err_spurious.
- Both units may grant in the same cycle, always to different requesters, since each requester has a single op.
- Both units may respond in the same cycle, to different owners.
- A requester that keeps req_valid high through its gnt cycle is masked by outstanding and does not get a second grant.
- Reset values: all outputs 0, rsp_data 0, both states U_IDLE, rr_ptrs 0, outstanding 0, err_spurious 0.
- Reset mid-operation: in-flight ops are abandoned and no rsp is issued. Requesters and units share rst_n.

## Timing
- Grant: eligible in cycle t → req_gnt and go high in cycle t+1, with operands valid on unit a/b in t+1.
- Requester may change operands from cycle t+2 on.
- Response: finish in cycle f → rsp_valid/rsp_data in cycle f+1.
- Re-issue: earliest next grant on the same unit is cycle f+2. Back-to-back unit occupancy gap is 1 idle cycle.
- End-to-end latency = unit latency + 2 cycles.
- Grant and response pulses are exactly one cycle wide.

## Test plan
- Single add: req0 add, a=1.0 (0x3FF0000000000000), b=2.0; unit finishes 5 cycles after go → req_gnt[0] at t+1, add_go at t+1, rsp_valid[0] one cycle after finish, rsp_data[0]=0x4008000000000000 (3.0).
- Contention: req0..3 all mul at t → grants at t+1, then successively in order 0,1,2,3 as each finishes; rr_ptr ends at 0; each rsp lands on the correct requester.
- Concurrency: req1 add and req2 mul at t → add_go and mul_go both at t+1. Force both finishes in the same cycle → rsp_valid = 4'b0110 next cycle, correct data per slot.
- Outstanding mask: req0 holds req_valid high through and after gnt → no second gnt until rsp_valid[0]. A new request is then granted 2 cycles after finish.
- Ready stall: add_ready=0 for 10 cycles with req3 add pending → no add_go or gnt. Grant occurs 1 cycle after ready rises.
- Spurious/reset: add_finish pulse while idle → err_spurious=1 and stays set. Assert rst_n=0 during a busy mul → all outputs 0 immediately, err_spurious cleared, no rsp after release.
